// File: rtl/note_scroller_pkg.sv
// guitar_pkg: shared geometry, timing constants and slot types for the note scroller.
package guitar_pkg;
  localparam int LANES = 4;
  localparam int SLOTS = 4;
  localparam int Y_W = 9;
  localparam int LANE_W = $clog2(LANES);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(480);
  localparam logic [Y_W:0] SPEED = (Y_W+1)'(2);
  localparam logic [Y_W-1:0] HIT_LO = Y_W'(400);
  localparam logic [Y_W-1:0] HIT_HI = Y_W'(440);
  typedef struct packed {
    logic valid;
    logic [Y_W-1:0] y;
  } note_slot_t;
  typedef logic [LANE_W-1:0] lane_idx_t;
  typedef logic [SLOT_W-1:0] slot_idx_t;
endpackage

// File: rtl/note_scroller_lane.sv
// note_lane: one lane of falling notes; advance, strum clear and spawn insert,
// all judged against the pre-edge slot state.
module note_lane
  import guitar_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  input  logic strum,
  input  logic spawn,
  output note_slot_t [SLOTS-1:0] slot_d,
  output logic hit,
  output logic miss,
  output logic accept
);
  note_slot_t [SLOTS-1:0] slot_q;
  logic cand, has_free;
  slot_idx_t sel, fsel;
  logic [Y_W-1:0] best;
  logic [Y_W:0] y_nxt;
  always_comb begin
    slot_d = slot_q;
    cand = 1'b0;
    has_free = 1'b0;
    sel = '0;
    fsel = '0;
    best = '0;
    y_nxt = '0;
    miss = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q[i].valid && slot_q[i].y >= HIT_LO && slot_q[i].y <= HIT_HI && (!cand || slot_q[i].y > best)) begin
        cand = 1'b1;
        sel = slot_idx_t'(i);
        best = slot_q[i].y;
      end
      if (!slot_q[i].valid && !has_free) begin
        has_free = 1'b1;
        fsel = slot_idx_t'(i);
      end
    end
    hit = strum & cand;
    accept = spawn & has_free;
    // strum clear beats advance beats insert; the insert slot was empty pre-edge
    for (int i = 0; i < SLOTS; i++) begin
      y_nxt = {1'b0, slot_q[i].y} + SPEED;
      if (hit && sel == slot_idx_t'(i)) begin
        slot_d[i] = '0;
      end else if (slot_q[i].valid && frame_tick) begin
        if (y_nxt >= Y_MAX) begin
          slot_d[i] = '0;
          miss = 1'b1;
        end else begin
          slot_d[i].y = y_nxt[Y_W-1:0];
        end
      end else if (accept && fsel == slot_idx_t'(i)) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].y = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) slot_q <= '0;
    else slot_q <= slot_d;
  end
endmodule

// File: rtl/note_scroller.sv
// note_scroller: per-lane falling-note field with strum judging and a registered render read port.
// Optional COMBO_COUNTER_EN adds a saturating hit-streak counter output.
module note_scroller
  import guitar_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  input  logic spawn_valid,
  input  lane_idx_t spawn_lane,
  input  logic strum_valid,
  input  lane_idx_t strum_lane,
  input  lane_idx_t rd_lane,
  input  slot_idx_t rd_slot,
  output logic [Y_W-1:0] rd_y,
  output logic rd_valid,
  output logic hit,
  output logic strum_miss,
  output logic note_miss,
  output logic spawn_drop
`ifdef COMBO_COUNTER_EN
  ,
  output logic [7:0] combo
`endif
);
  note_slot_t [LANES-1:0][SLOTS-1:0] lane_d;
  logic [LANES-1:0] lane_hit, lane_miss, lane_acc;
  logic hit_d, hit_q, strum_miss_d, strum_miss_q, note_miss_d, note_miss_q, spawn_drop_d, spawn_drop_q;
  note_slot_t rd_note_d, rd_note_q;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane u_lane (
      .clock(clock),
      .resetn(resetn),
      .frame_tick(frame_tick),
      .strum(strum_valid && strum_lane == lane_idx_t'(l)),
      .spawn(spawn_valid && spawn_lane == lane_idx_t'(l)),
      .slot_d(lane_d[l]),
      .hit(lane_hit[l]),
      .miss(lane_miss[l]),
      .accept(lane_acc[l])
    );
  end
`ifdef COMBO_COUNTER_EN
  logic [7:0] combo_d, combo_q;
`endif
  always_comb begin
    hit_d = |lane_hit;
    note_miss_d = |lane_miss;
    strum_miss_d = strum_valid & ~hit_d;
    spawn_drop_d = spawn_valid & ~|lane_acc;
    rd_note_d = (int'(rd_lane) < LANES) ? lane_d[rd_lane][rd_slot] : '0;
`ifdef COMBO_COUNTER_EN
    combo_d = (strum_miss_d | note_miss_d) ? 8'd0 : (hit_d && combo_q != 8'hff) ? combo_q + 8'd1 : combo_q;
`endif
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_q <= 1'b0;
      strum_miss_q <= 1'b0;
      note_miss_q <= 1'b0;
      spawn_drop_q <= 1'b0;
      rd_note_q <= '0;
`ifdef COMBO_COUNTER_EN
      combo_q <= '0;
`endif
    end else begin
      hit_q <= hit_d;
      strum_miss_q <= strum_miss_d;
      note_miss_q <= note_miss_d;
      spawn_drop_q <= spawn_drop_d;
      rd_note_q <= rd_note_d;
`ifdef COMBO_COUNTER_EN
      combo_q <= combo_d;
`endif
    end
  end
  assign hit = hit_q;
  assign strum_miss = strum_miss_q;
  assign note_miss = note_miss_q;
  assign spawn_drop = spawn_drop_q;
  assign rd_y = rd_note_q.y;
  assign rd_valid = rd_note_q.valid;
`ifdef COMBO_COUNTER_EN
  assign combo = combo_q;
`endif
endmodule

// File: tb/tb_note_scroller.sv
// tb_note_scroller: directed stimulus with a queued expectation scoreboard and a negedge monitor.
module tb_note_scroller;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0, spawn_valid = 1'b0, strum_valid = 1'b0;
  logic [1:0] spawn_lane = '0, strum_lane = '0, rd_lane = '0, rd_slot = '0;
  logic [8:0] rd_y;
  logic rd_valid, hit, strum_miss, note_miss, spawn_drop;
`ifdef COMBO_COUNTER_EN
  logic [7:0] combo;
`endif
  localparam logic [3:0] H = 4'b1000, SM = 4'b0100, NM = 4'b0010, DR = 4'b0001, P0 = 4'b0000;
  typedef struct {
    int cyc;
    bit chk;
    bit v;
    logic [8:0] y;
    logic [3:0] p;
    int c;
  } exp_t;
  exp_t q[$];
  string nq[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  note_scroller dut (
    .clock(clock),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane),
    .strum_valid(strum_valid),
    .strum_lane(strum_lane),
    .rd_lane(rd_lane),
    .rd_slot(rd_slot),
    .rd_y(rd_y),
    .rd_valid(rd_valid),
    .hit(hit),
    .strum_miss(strum_miss),
    .note_miss(note_miss),
    .spawn_drop(spawn_drop)
`ifdef COMBO_COUNTER_EN
    ,
    .combo(combo)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      string nm;
      logic [3:0] ap;
      int ac;
      bit bad;
      e = q.pop_front();
      nm = nq.pop_front();
      ap = {hit, strum_miss, note_miss, spawn_drop};
      bad = (ap !== e.p) || (e.chk && (rd_valid !== e.v || rd_y !== e.y));
`ifdef COMBO_COUNTER_EN
      ac = int'(combo);
      bad = bad || (e.c >= 0 && ac != e.c);
`else
      ac = 0;
`endif
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got rd_valid=%0b rd_y=%0d pulses(h,sm,nm,dr)=%b combo=%0d; want rd_valid=%0b rd_y=%0d pulses=%b combo=%0d (rd checked=%0b)",
                 nm, cyc, rd_valid, rd_y, ap, ac, e.v, e.y, e.p, e.c, e.chk);
      end
    end
  end

  task automatic go(input string nm, input bit chk, input bit v, input int y, input logic [3:0] p, input int c);
    exp_t e;
    e.cyc = cyc + 1;
    e.chk = chk;
    e.v = v;
    e.y = 9'(y);
    e.p = p;
    e.c = c;
    q.push_back(e);
    nq.push_back(nm);
    @(negedge clock);
    frame_tick = 1'b0;
    spawn_valid = 1'b0;
    strum_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    go("reset", 1, 0, 0, P0, 0);
    resetn = 1'b1;
  endtask

  task automatic ticks(input string nm, input int n, input int c);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      go(nm, 0, 0, 0, P0, c);
    end
  endtask

  initial begin
    go("por", 1, 0, 0, P0, 0);
    resetn = 1'b1;
    // reset in the middle of scrolling
    rd_lane = 2'd1; rd_slot = 2'd0;
    spawn_valid = 1'b1; spawn_lane = 2'd1;
    go("spawn_l1", 1, 1, 0, P0, 0);
    for (int k = 1; k <= 3; k++) begin
      frame_tick = 1'b1;
      go("tick_l1", 1, 1, 2 * k, P0, 0);
    end
    resetn = 1'b0;
    go("rst_mid", 1, 0, 0, P0, 0);
    resetn = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s);
      go("rd_after_rst", 1, 0, 0, P0, 0);
    end
    // scroll to the bottom and retire
    rd_lane = 2'd0; rd_slot = 2'd0;
    spawn_valid = 1'b1; spawn_lane = 2'd0;
    go("spawn_l0", 1, 1, 0, P0, 0);
    for (int k = 1; k <= 239; k++) begin
      frame_tick = 1'b1;
      go("scroll", 1, 1, 2 * k, P0, 0);
    end
    frame_tick = 1'b1;
    go("retire", 1, 0, 0, NM, 0);
    go("single_miss", 1, 0, 0, P0, 0);
    // hit window bounds and largest-y selection
    do_reset();
    rd_lane = 2'd2; rd_slot = 2'd0;
    spawn_valid = 1'b1; spawn_lane = 2'd2;
    go("spawn_a", 1, 1, 0, P0, 0);
    ticks("t_a", 20, 0);
    spawn_valid = 1'b1;
    go("spawn_b", 1, 1, 40, P0, 0);
    ticks("t_ab", 200, 0);
    go("a_at_440", 1, 1, 440, P0, 0);
    strum_valid = 1'b1; strum_lane = 2'd2;
    go("hit_440", 1, 0, 0, H, 1);
    rd_slot = 2'd1;
    go("b_at_400", 1, 1, 400, P0, 1);
    strum_valid = 1'b1;
    go("hit_400", 1, 0, 0, H, 2);
    rd_slot = 2'd0; spawn_valid = 1'b1;
    go("spawn_d", 1, 1, 0, P0, 2);
    ticks("t_d", 21, 2);
    rd_slot = 2'd1; spawn_valid = 1'b1;
    go("spawn_c", 1, 1, 0, P0, 2);
    ticks("t_dc", 199, 2);
    rd_slot = 2'd0;
    go("d_at_440", 1, 1, 440, P0, 2);
    strum_valid = 1'b1;
    go("hit_third", 1, 0, 0, H, 3);
    rd_slot = 2'd1; strum_valid = 1'b1;
    go("miss_398", 1, 1, 398, SM, 0);
    // lane full
    do_reset();
    rd_lane = 2'd3; spawn_lane = 2'd3;
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s); spawn_valid = 1'b1;
      go("fill_l3", 1, 1, 0, P0, 0);
    end
    spawn_valid = 1'b1;
    go("drop_5th", 1, 1, 0, DR, 0);
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s);
      go("full_rd", 1, 1, 0, P0, 0);
    end
    // tick + strum + spawn on a full lane in one cycle
    do_reset();
    rd_lane = 2'd1; rd_slot = 2'd0; spawn_lane = 2'd1; strum_lane = 2'd1;
    spawn_valid = 1'b1;
    go("spawn_x", 1, 1, 0, P0, 0);
    for (int k = 1; k <= 10; k++) begin
      frame_tick = 1'b1;
      go("tick_x", 1, 1, 2 * k, P0, 0);
    end
    for (int s = 1; s < 4; s++) begin
      rd_slot = 2'(s); spawn_valid = 1'b1;
      go("fill_l1", 1, 1, 0, P0, 0);
    end
    ticks("t_l1", 200, 0);
    rd_slot = 2'd0; frame_tick = 1'b1; strum_valid = 1'b1; spawn_valid = 1'b1;
    go("simul", 1, 0, 0, H | DR, 1);
    spawn_valid = 1'b1;
    go("refill", 1, 1, 0, P0, 1);
    rd_slot = 2'd1;
    go("adv_s1", 1, 1, 402, P0, 1);
    rd_slot = 2'd3;
    go("adv_s3", 1, 1, 402, P0, 1);
    @(negedge clock);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
